piso_serial_tx: RTL and testbench
=================================

Name: piso_serial_tx

Overview:
Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock. The serial pin is registered, and a registered complement is driven alongside it. It is the transmit end of the single-bit registered serial links in our test designs, and it feeds the flop-based capture stages downstream.

Parameters:
WIDTH, 8, bits per frame; legal range 2..64.
LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.
GAP_CYCLES, 0, idle cycles forced after each frame; legal range 0..255.

Ports:
clk  input  1  clock; all logic is rising-edge.
reset  input  1  reset, synchronous, active-high.
load_valid  input  1  producer has a word on load_data.
load_ready  output  1  block can accept a word; combinational from registered state only.
load_data  input  WIDTH  word to transmit; sampled only on handshake.
ser_out  output  1  registered serial data.
ser_out_bar  output  1  registered complement of ser_out.
ser_valid  output  1  ser_out carries a frame bit this cycle.
frame_start  output  1  one-cycle pulse on the first bit of a frame.
frame_done  output  1  one-cycle pulse on the last bit of a frame.
busy  output  1  state is not IDLE.

Behaviour:
- FSM states: IDLE, SHIFT, GAP. Plus a shift register of WIDTH bits and a bit counter of $clog2(WIDTH) bits.
- Reset values, applied at the first edge with reset=1: state=IDLE, ser_out=0, ser_out_bar=1, ser_valid=0, frame_start=0, frame_done=0, busy=0, counter=0. Shift register contents are don't-care.
- Reset mid-frame: the partial frame is abandoned. No frame_done is emitted, and the word is not re-sent.
- Handshake: a word is accepted at the edge where load_valid && load_ready. load_valid with load_ready=0 has no effect. There is no internal buffering beyond the single shift register.
- load_ready = (state==IDLE) || (state==SHIFT && last_bit && GAP_CYCLES==0).
- Latency: handshake at edge N. First bit appears on ser_out in the cycle after edge N, with ser_valid=1 and frame_start=1. Bit k appears k cycles later. The last bit coincides with frame_done=1.
- Bit order: LSB_FIRST=1 sends load_data[0], [1], … [WIDTH-1]. LSB_FIRST=0 sends [WIDTH-1] … [0].
- ser_out_bar == !ser_out in every cycle, including reset and idle.
- IDLE: ser_out=0, ser_valid=0, and both pulses are 0.
- SHIFT: lasts exactly WIDTH cycles; the counter runs 0..WIDTH-1. On the last bit:
  - If GAP_CYCLES>0: go to GAP.
  - Else if a new handshake occurs: stay in SHIFT, reload, reset the counter to 0. The next cycle shows the new word's first bit with frame_start=1, with no idle cycle between frames.
  - Else: go to IDLE.
- GAP: lasts exactly GAP_CYCLES cycles, with ser_valid=0, ser_out=0 and load_ready=0; then IDLE.
- Counter arithmetic is unsigned. Comparisons are against WIDTH-1 and GAP_CYCLES-1; the counter never wraps mid-frame.
- load_data changing while not handshaking has no effect on the frame in flight.

Decomposition:
- Shared package piso_serial_pkg holds:
  - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2);
  - the counter-width function clog2.
- One natural sub-module: mod_down_counter, a loadable down-counter with a zero flag. It is instantiated once for the bit count and once for the gap count.
- Everything else stays in piso_serial_tx.

Test Plan:
- Single word, WIDTH=8, LSB_FIRST=1, GAP=0: load 8'hA5 at edge N.
  - ser_out is 1,0,1,0,0,1,0,1 over cycles N+1..N+8, with ser_out_bar inverted.
  - frame_start=1 only at N+1, frame_done=1 only at N+8.
  - ser_valid=0 at N+9, and busy drops at N+9.
- MSB first, LSB_FIRST=0: load 8'h3C -> ser_out is 0,0,1,1,1,1,0,0, with pulses as above.
- Back-to-back, GAP=0: load_valid held high with 8'hA5 then 8'h3C.
  - Second handshake occurs at the edge ending cycle N+8.
  - 16 contiguous ser_valid cycles; frame_start at N+1 and N+9; frame_done at N+8 and N+16.
- GAP_CYCLES=3: after frame_done at N+8, load_ready=0 and ser_valid=0 for N+9..N+11.
  - load_ready=1 at N+12; a word held on load_valid is accepted at the edge ending N+12.
- Load while busy: a new load_data toggles with load_valid=1 during N+2..N+7 (GAP=0).
  - No handshake occurs until the last bit, and the transmitted bits of 8'hA5 are unchanged.
- Reset mid-frame: reset=1 during cycle N+4.
  - From N+5: ser_out=0, ser_out_bar=1, ser_valid=0, busy=0, no frame_done, load_ready=1.
  - A following load of 8'hFF transmits eight 1s correctly.

Source files
------------

// File: rtl/piso_serial_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter:
// FSM state encoding, gap counter width and a counter-width helper.
package piso_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Wide enough for any legal gap length (up to 255 cycles).
  localparam int unsigned GAP_CNT_W = 8;

  // Number of bits needed to hold values 0..n-1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (((n - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_down_counter.sv
// Loadable down-counter with a zero flag. Holds at zero instead of wrapping.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset (count -> 0)
//   i_load       load i_load_val (takes priority over decrement)
//   i_load_val   value to load
//   i_dec        decrement by one when non-zero
//   o_count      current count
//   o_zero       count equals zero
module mod_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Count register; saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a
// valid/ready handshake and shifts it out one bit per clock on a registered
// pin, with a registered complement, frame pulses and an optional idle gap.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   load_valid    producer has a word on load_data
//   load_ready    block can accept a word (from registered state only)
//   load_data     word to transmit, sampled on handshake
//   ser_out       registered serial data
//   ser_out_bar   registered complement of ser_out
//   ser_valid     ser_out carries a frame bit
//   frame_start   pulse on the first bit of a frame
//   frame_done    pulse on the last bit of a frame
//   busy          FSM is not idle
module piso_serial_tx
  import piso_serial_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_out_bar,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned CNT_W    = clog2(WIDTH);
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  state_e             r_state;
  state_e             w_next_state;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_next;
  logic               r_ser_out;
  logic               r_ser_out_bar;
  logic               r_ser_valid;
  logic               r_frame_start;
  logic               r_frame_done;
  logic               w_ser_next;
  logic               w_valid_next;
  logic               w_fs_next;
  logic               w_fd_next;
  logic               w_hs;
  logic               w_bit_load;
  logic               w_bit_dec;
  logic [CNT_W-1:0]   w_bit_cnt;
  logic               w_bit_zero;
  logic               w_bit_one;
  logic               w_gap_load;
  logic               w_gap_dec;
  logic [GAP_CNT_W-1:0] w_gap_cnt_unused;
  logic               w_gap_zero;

  // Bit that goes on the pin next, given the remaining shift contents.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // Shift contents after the leading bit has been consumed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign load_ready = (r_state == ST_IDLE) ||
                      ((r_state == ST_SHIFT) && w_bit_zero && (GAP_CYCLES == 0));
  assign w_hs       = load_valid && load_ready;
  assign w_bit_one  = (w_bit_cnt == CNT_W'(1));
  assign busy       = (r_state != ST_IDLE);

  // Bit counter holds the number of bits still to follow the one on the pin.
  mod_down_counter #(.W(CNT_W)) u_bit_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_bit_load),
    .i_load_val (CNT_W'(WIDTH - 1)),
    .i_dec      (w_bit_dec),
    .o_count    (w_bit_cnt),
    .o_zero     (w_bit_zero)
  );

  // Gap length only needs the zero flag.
  mod_down_counter #(.W(GAP_CNT_W)) u_gap_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_gap_load),
    .i_load_val (GAP_CNT_W'(GAP_LOAD)),
    .i_dec      (w_gap_dec),
    .o_count    (w_gap_cnt_unused),
    .o_zero     (w_gap_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    w_next_state = r_state;
    w_shift_next = r_shift;
    w_ser_next   = 1'b0;
    w_valid_next = 1'b0;
    w_fs_next    = 1'b0;
    w_fd_next    = 1'b0;
    w_bit_load   = 1'b0;
    w_bit_dec    = 1'b0;
    w_gap_load   = 1'b0;
    w_gap_dec    = 1'b0;

    case (r_state)
      ST_SHIFT: begin
        if (!w_bit_zero) begin
          w_shift_next = advance(r_shift);
          w_ser_next   = first_bit(r_shift);
          w_valid_next = 1'b1;
          w_fd_next    = w_bit_one;
          w_bit_dec    = 1'b1;
        end else if (GAP_CYCLES != 0) begin
          w_next_state = ST_GAP;
          w_gap_load   = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (w_gap_zero) w_next_state = ST_IDLE;
        else            w_gap_dec    = 1'b1;
      end
      default: w_next_state = ST_IDLE;
    endcase

    // Handshake only fires when idle or on a gapless last bit; it overrides.
    if (w_hs) begin
      w_next_state = ST_SHIFT;
      w_shift_next = advance(load_data);
      w_ser_next   = first_bit(load_data);
      w_valid_next = 1'b1;
      w_fs_next    = 1'b1;
      w_fd_next    = 1'b0;
      w_bit_load   = 1'b1;
    end
  end

  // Shift register and registered pin/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift       <= '0;
      r_ser_out     <= 1'b0;
      r_ser_out_bar <= 1'b1;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_shift       <= w_shift_next;
      r_ser_out     <= w_ser_next;
      r_ser_out_bar <= ~w_ser_next;
      r_ser_valid   <= w_valid_next;
      r_frame_start <= w_fs_next;
      r_frame_done  <= w_fd_next;
    end
  end

  assign ser_out     = r_ser_out;
  assign ser_out_bar = r_ser_out_bar;
  assign ser_valid   = r_ser_valid;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: three instances (LSB-first/no gap, MSB-first/no
// gap, LSB-first/3-cycle gap) share clock, reset and data. A timeline model
// schedules each accepted word as WIDTH bit slots plus gap slots and every
// cycle checks all outputs of all three instances against it.
module tb_piso_serial_tx;

  localparam int W    = 8;
  localparam int G2   = 3;
  localparam int NCYC = 2048;

  typedef struct packed {
    logic v;
    logic b;
    logic fs;
    logic fd;
    logic gap;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] lv;
  logic [7:0] ld;
  logic [2:0] rdy, so, sob, sv, fs, fd, bz;

  rec_t tl [3][NCYC];
  int   cyc;
  int   n_cmp;
  int   n_err;
  logic [2:0] got_hs;

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(rdy[0]),
    .load_data(ld), .ser_out(so[0]), .ser_out_bar(sob[0]), .ser_valid(sv[0]),
    .frame_start(fs[0]), .frame_done(fd[0]), .busy(bz[0]));

  piso_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b0), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(rdy[1]),
    .load_data(ld), .ser_out(so[1]), .ser_out_bar(sob[1]), .ser_valid(sv[1]),
    .frame_start(fs[1]), .frame_done(fd[1]), .busy(bz[1]));

  piso_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .GAP_CYCLES(G2)) u_dut2 (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(rdy[2]),
    .load_data(ld), .ser_out(so[2]), .ser_out_bar(sob[2]), .ser_valid(sv[2]),
    .frame_start(fs[2]), .frame_done(fd[2]), .busy(bz[2]));

  function automatic int gap_of(input int i);
    return (i == 2) ? G2 : 0;
  endfunction

  function automatic bit lsb_of(input int i);
    return (i != 1);
  endfunction

  task automatic chk(input string tag, input int d, input logic obs, input logic want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s dut%0d cyc%0d: got %b want %b", tag, d, cyc, obs, want);
    end
  endtask

  // Place a frame for word w on instance i's timeline starting next cycle.
  task automatic schedule(input int i, input logic [7:0] w);
    rec_t r;
    for (int j = 0; j < W; j++) begin
      r     = '0;
      r.v   = 1'b1;
      r.b   = lsb_of(i) ? w[j] : w[W-1-j];
      r.fs  = (j == 0);
      r.fd  = (j == W - 1);
      tl[i][cyc+1+j] = r;
    end
    for (int g = 0; g < gap_of(i); g++) begin
      r     = '0;
      r.gap = 1'b1;
      tl[i][cyc+1+W+g] = r;
    end
  endtask

  // Check the current cycle, update the model, advance one clock.
  task automatic cycle();
    rec_t e, nx;
    logic er, hs;
    if (cyc >= NCYC - 24) begin
      $display("FAIL cycle_budget: cyc %0d exceeds limit %0d", cyc, NCYC - 24);
      $fatal(1, "cycle budget exhausted");
    end
    for (int i = 0; i < 3; i++) begin
      e  = tl[i][cyc];
      nx = tl[i][cyc+1];
      er = !e.gap && !nx.v && !nx.gap;
      chk("ser_out",     i, so[i],  e.b);
      chk("ser_out_bar", i, sob[i], ~e.b);
      chk("ser_valid",   i, sv[i],  e.v);
      chk("frame_start", i, fs[i],  e.fs);
      chk("frame_done",  i, fd[i],  e.fd);
      chk("busy",        i, bz[i],  e.v | e.gap);
      chk("load_ready",  i, rdy[i], er);
      hs        = lv[i] && er && !reset;
      got_hs[i] = hs;
      if (reset) begin
        for (int k = 1; k <= W + 4; k++) tl[i][cyc+k] = '0;
      end else if (hs) begin
        schedule(i, ld);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) cycle();
  endtask

  // Hold a word on instance i until it is accepted (bounded).
  task automatic send(input int i, input logic [7:0] w);
    bit done;
    done  = 1'b0;
    ld    = w;
    lv[i] = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      cycle();
      done = got_hs[i];
    end
    lv[i] = 1'b0;
    n_cmp++;
    assert (done) else begin
      n_err++;
      $error("FAIL handshake dut%0d cyc%0d: accepted %0b want 1", i, cyc, done);
    end
  endtask

  initial begin
    reset  = 1'b1;
    lv     = '0;
    ld     = '0;
    cyc    = 0;
    n_cmp  = 0;
    n_err  = 0;
    got_hs = '0;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < NCYC; c++) tl[i][c] = '0;

    // Reset state, checked while reset is still asserted.
    @(posedge clk);
    #1;
    cycle();
    reset = 1'b0;
    idle(2);

    // Single word, LSB first.
    send(0, 8'hA5);
    idle(10);

    // Single word, MSB first.
    send(1, 8'h3C);
    idle(10);

    // Back-to-back frames, no gap.
    send(0, 8'hA5);
    send(0, 8'h3C);
    idle(10);

    // Attempted loads while busy with changing data.
    send(0, 8'hA5);
    for (int t = 0; t < 6; t++) begin
      lv[0] = 1'b1;
      ld    = 8'($urandom);
      cycle();
    end
    lv[0] = 1'b0;
    idle(6);

    // Gap of three cycles between frames.
    send(2, 8'hA5);
    send(2, 8'h3C);
    idle(16);

    // Reset in the middle of a frame, then a fresh frame.
    send(0, 8'hA5);
    idle(3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    send(0, 8'hFF);
    idle(10);

    // Random valids, data and occasional resets on all instances.
    for (int t = 0; t < 300; t++) begin
      lv    = 3'($urandom);
      ld    = 8'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      cycle();
    end
    reset = 1'b0;
    lv    = '0;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
